send_buffers: RTL

- Transmitting end of the median partition loop; the partition/classify stage is the receiver and sits directly downstream.
- Captures each partition pass's lower/larger pixels into ping-pong storage.
- At fill completion, decides which partition holds the median, then drives the next pass by:
  - sourcing the new pivot and buffer size;
  - streaming the selected partition's pixels back out, one per cycle.
- Ends when the median lands in the equal partition or in a constant-valued partition.

---
 rtl/median_pkg.sv | 28 ++
 rtl/pingpong_px_ram.sv | 37 +++
 rtl/send_buffers.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/median_pkg.sv
// Shared types and constants for the median partition loop.
// Optional build macro used by send_buffers: SEND_BUFFERS_ITER_LIMIT_EN.
package median_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DECIDE,
    ST_SEND,
    ST_DONE
  } state_t;

  typedef enum logic {
    PART_LOWER,
    PART_LARGER
  } part_t;

  localparam logic [7:0]  PIVOT_INIT = 8'd128;
  localparam int unsigned ITER_MAX   = 10;

  // Rounded-up midpoint of a range, computed 9-bit so min+max+1 cannot wrap.
  function automatic logic [7:0] mid_pivot(input logic [7:0] lo, input logic [7:0] hi);
    logic [8:0] sum;
    sum = {1'b0, lo} + {1'b0, hi} + 9'd1;
    return sum[8:1];
  endfunction

endpackage

// File: rtl/pingpong_px_ram.sv
// Two-bank pixel store: writes land in the write bank, reads come from the
// other bank through a registered read port; swap exchanges the banks.
module pingpong_px_ram #(
  parameter int unsigned BUFF_SIZE = 32,
  parameter int unsigned ADDR_W    = $clog2(BUFF_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              swap,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2][BUFF_SIZE];
  logic       bank_sel;

  // Storage array write into the current write bank (no reset on the array).
  always_ff @(posedge clk) begin
    if (we) mem[bank_sel][waddr] <= wdata;
  end

  // Bank select toggle and registered read from the opposite bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel <= 1'b0;
      rdata    <= '0;
    end else begin
      if (swap) bank_sel <= ~bank_sel;
      if (re)   rdata    <= mem[~bank_sel][raddr];
    end
  end

endmodule

// File: rtl/send_buffers.sv
// Transmit end of the median partition loop: stores each pass's lower/larger
// pixels, picks the partition holding the sought rank and re-sends it.
// Optional build macro: SEND_BUFFERS_ITER_LIMIT_EN (adds iter_abort).
module send_buffers
  import median_pkg::*;
#(
  parameter int unsigned BUFF_SIZE     = 32,
  parameter int unsigned BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init_valid,
  input  logic [BUFF_SIZE_BIT-1:0] init_size,
  input  logic [BUFF_SIZE_BIT-1:0] init_pos,
  input  logic [7:0]               in_px,
  input  logic                     new_lower,
  input  logic                     new_larger,
  input  logic [BUFF_SIZE_BIT-1:0] lower_size,
  input  logic [BUFF_SIZE_BIT-1:0] equal_size,
  input  logic [BUFF_SIZE_BIT-1:0] larger_size,
  input  logic [7:0]               min_lower,
  input  logic [7:0]               max_lower,
  input  logic [7:0]               min_larger,
  input  logic [7:0]               max_larger,
  input  logic                     fill_done,
  output logic [7:0]               pivot,
  output logic [BUFF_SIZE_BIT-1:0] buff_size,
  output logic [7:0]               out_px,
  output logic                     out_px_valid,
  output logic                     out_px_empty,
  output logic                     send_req,
  output logic                     sending,
  output logic [7:0]               median,
  output logic                     median_valid,
`ifdef SEND_BUFFERS_ITER_LIMIT_EN
  output logic                     iter_abort,
`endif
  output logic                     busy
);

  localparam int unsigned AW = $clog2(BUFF_SIZE);
  localparam logic [AW-1:0] TOP_ADDR = AW'(BUFF_SIZE - 1);

  state_t                   state;
  part_t                    part_sel;
  logic [BUFF_SIZE_BIT-1:0] pos;
  logic [AW-1:0]            wr_lo, wr_hi;
  logic [BUFF_SIZE_BIT-1:0] rd_cnt;
  logic [BUFF_SIZE_BIT-1:0] snap_l, snap_e, snap_g;
  logic [7:0]               snap_minl, snap_maxl, snap_ming, snap_maxg;

  logic                     we, re, swap;
  logic [AW-1:0]            waddr, raddr;
  logic [BUFF_SIZE_BIT:0]   sum_le;
  part_t                    dec_part;
  logic                     hit_eq, flat, cont, iter_hit;
  logic [7:0]               dmin, dmax;
  logic [BUFF_SIZE_BIT-1:0] dsize;

`ifdef SEND_BUFFERS_ITER_LIMIT_EN
  logic [3:0] iter_cnt;
  assign iter_hit = (iter_cnt == 4'(ITER_MAX - 1));
`else
  assign iter_hit = 1'b0;
`endif

  assign busy         = (state != ST_IDLE);
  assign out_px_empty = ~out_px_valid;

  // Capture/readback addressing: lower grows up from 0, larger grows down from the top.
  always_comb begin
    we    = ((state == ST_FILL) || (state == ST_SEND)) && (new_lower || new_larger);
    waddr = new_lower ? wr_lo : (TOP_ADDR - wr_hi);
    re    = (state == ST_SEND) && (rd_cnt < buff_size);
    raddr = (part_sel == PART_LOWER) ? rd_cnt[AW-1:0] : (TOP_ADDR - rd_cnt[AW-1:0]);
  end

  // Partition choice from the snapshotted pass statistics.
  always_comb begin
    sum_le   = {1'b0, snap_l} + {1'b0, snap_e};
    hit_eq   = 1'b0;
    dec_part = PART_LOWER;
    dmin     = snap_minl;
    dmax     = snap_maxl;
    dsize    = snap_l;
    if (pos < snap_l) begin
      dec_part = PART_LOWER;
    end else if ({1'b0, pos} < sum_le) begin
      hit_eq = 1'b1;
    end else begin
      dec_part = PART_LARGER;
      dmin     = snap_ming;
      dmax     = snap_maxg;
      dsize    = snap_g;
    end
    flat = (dmin == dmax);
    cont = !hit_eq && !flat;
    swap = (state == ST_DECIDE) && cont && !iter_hit;
  end

  pingpong_px_ram #(
    .BUFF_SIZE (BUFF_SIZE),
    .ADDR_W    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .swap  (swap),
    .we    (we),
    .waddr (waddr),
    .wdata (in_px),
    .re    (re),
    .raddr (raddr),
    .rdata (out_px)
  );

  // Main FSM with registered outputs and write/read counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      part_sel     <= PART_LOWER;
      pos          <= '0;
      wr_lo        <= '0;
      wr_hi        <= '0;
      rd_cnt       <= '0;
      snap_l       <= '0;
      snap_e       <= '0;
      snap_g       <= '0;
      snap_minl    <= '0;
      snap_maxl    <= '0;
      snap_ming    <= '0;
      snap_maxg    <= '0;
      pivot        <= PIVOT_INIT;
      buff_size    <= '0;
      out_px_valid <= 1'b0;
      send_req     <= 1'b0;
      sending      <= 1'b0;
      median       <= '0;
      median_valid <= 1'b0;
`ifdef SEND_BUFFERS_ITER_LIMIT_EN
      iter_cnt     <= '0;
      iter_abort   <= 1'b0;
`endif
    end else begin
      send_req     <= 1'b0;
      median_valid <= 1'b0;
      // valid follows the read issue by one cycle, matching the RAM latency
      out_px_valid <= re;
      if (we) begin
        if (new_lower) wr_lo <= wr_lo + 1'b1;
        else           wr_hi <= wr_hi + 1'b1;
      end
      case (state)
        ST_IDLE: begin
`ifdef SEND_BUFFERS_ITER_LIMIT_EN
          iter_cnt <= '0;
`endif
          if (init_valid) begin
            pos       <= init_pos;
            buff_size <= init_size;
            pivot     <= PIVOT_INIT;
            wr_lo     <= '0;
            wr_hi     <= '0;
`ifdef SEND_BUFFERS_ITER_LIMIT_EN
            iter_abort <= 1'b0;
`endif
            state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (fill_done) begin
            snap_l    <= lower_size;
            snap_e    <= equal_size;
            snap_g    <= larger_size;
            snap_minl <= min_lower;
            snap_maxl <= max_lower;
            snap_ming <= min_larger;
            snap_maxg <= max_larger;
            state     <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
`ifdef SEND_BUFFERS_ITER_LIMIT_EN
          iter_cnt <= iter_cnt + 1'b1;
`endif
          if (hit_eq) begin
            median       <= pivot;
            median_valid <= 1'b1;
            state        <= ST_DONE;
          end else if (flat) begin
            median       <= dmin;
            median_valid <= 1'b1;
            state        <= ST_DONE;
          end else if (iter_hit) begin
            median       <= pivot;
            median_valid <= 1'b1;
`ifdef SEND_BUFFERS_ITER_LIMIT_EN
            iter_abort   <= 1'b1;
`endif
            state        <= ST_DONE;
          end else begin
            pivot     <= mid_pivot(dmin, dmax);
            buff_size <= dsize;
            send_req  <= 1'b1;
            sending   <= 1'b1;
            part_sel  <= dec_part;
            rd_cnt    <= '0;
            wr_lo     <= '0;
            wr_hi     <= '0;
            if (dec_part == PART_LARGER) pos <= pos - sum_le[BUFF_SIZE_BIT-1:0];
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (re) begin
            rd_cnt <= rd_cnt + 1'b1;
          end else begin
            sending <= 1'b0;
            state   <= ST_FILL;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
